// File: rtl/i2c_target_if.sv
// Open-drain I2C pad bundle between a bus master model and the target.
// The target only pulls SDA low; the raw line is seen back on sda_in.
interface i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe
    );

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe
    );
endinterface

// File: rtl/i2c_target.sv
// Oversampled I2C target with one device address and a small byte bank.
// Supports pointer write, auto-increment burst write and burst read.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    i2c_target_if.slave   bus,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data,
    output logic          busy,
    output logic          addressed
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t state, state_n;

    logic [2:0]    scl_q, sda_q;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          rw, rw_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          oe, oe_n;
    logic          busy_n, addr_n, stb_n;
    logic [AW-1:0] waddr_n;
    logic [7:0]    wdata_n;
    logic          bank_we;
    logic [7:0]    bank [2**AW];

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start, stop;
    logic [7:0] byte_in, rd_byte;

    assign scl_s = scl_q[1];
    assign scl_h = scl_q[2];
    assign sda_s = sda_q[1];
    assign sda_h = sda_q[2];

    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

    assign byte_in    = {shreg[6:0], sda_s};
    assign rd_byte    = bank[ptr];
    assign dbg_data   = bank[dbg_addr];
    assign bus.sda_oe = oe;

    // [0:1] synchronize the pads, [2] is the history sample for edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], bus.scl_in};
            sda_q <= {sda_q[1:0], bus.sda_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            oe        <= 1'b0;
            busy      <= 1'b0;
            addressed <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 0; i < 2**AW; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            rw        <= rw_n;
            ptr       <= ptr_n;
            oe        <= oe_n;
            busy      <= busy_n;
            addressed <= addr_n;
            wr_stb    <= stb_n;
            wr_addr   <= waddr_n;
            wr_data   <= wdata_n;
            if (bank_we) begin
                bank[waddr_n] <= wdata_n;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        rw_n    = rw;
        ptr_n   = ptr;
        oe_n    = oe;
        busy_n  = busy;
        addr_n  = addressed;
        stb_n   = 1'b0;
        waddr_n = wr_addr;
        wdata_n = wr_data;
        bank_we = 1'b0;

        if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
            addr_n  = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            addr_n  = 1'b0;
        end else begin
            unique case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                addr_n  = 1'b1;
                                rw_n    = byte_in[0];
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            ptr_n   = byte_in[AW-1:0];
                            state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bank_we = 1'b1;
                            stb_n   = 1'b1;
                            waddr_n = ptr;
                            wdata_n = byte_in;
                            ptr_n   = ptr + AW'(1);
                            state_n = WDATA_ACK;
                        end
                    end
                end
                // cnt 0: first fall pulls ACK; cnt 1: second fall ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            oe_n  = 1'b1;
                            cnt_n = 3'd1;
                        end else begin
                            oe_n  = 1'b0;
                            cnt_n = '0;
                            if (state == ADDR_ACK && rw) begin
                                shreg_n = rd_byte;
                                ptr_n   = ptr + AW'(1);
                                oe_n    = ~rd_byte[7];
                                cnt_n   = 3'd1;
                                state_n = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                // cnt counts bits already driven; wraps to 0 after the 8th
                RDATA: begin
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            oe_n    = 1'b0;
                            state_n = RDATA_ACK;
                        end else begin
                            oe_n    = ~shreg[6];
                            shreg_n = {shreg[6:0], 1'b0};
                            cnt_n   = cnt + 3'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            oe_n    = 1'b0;
                            state_n = IGNORE;
                        end else begin
                            cnt_n = 3'd1;
                        end
                    end else if (scl_fall && cnt == 3'd1) begin
                        shreg_n = rd_byte;
                        ptr_n   = ptr + AW'(1);
                        oe_n    = ~rd_byte[7];
                        cnt_n   = 3'd1;
                        state_n = RDATA;
                    end
                end
                IDLE, IGNORE: begin
                    oe_n = 1'b0;
                end
                default: begin
                    oe_n    = 1'b0;
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged master, write/read scoreboards,
// bank model checked through the debug read port.
module tb_i2c_target;
    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic       busy;
    logic       addressed;

    i2c_target_if bus ();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target #(
        .DEV_ADDR(7'h39),
        .AW      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy     (busy),
        .addressed(addressed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  model[16];
    bit          oe_seen;
    bit          adr_seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.sda_oe) oe_seen = 1'b1;
            if (addressed) adr_seen = 1'b1;
            if (wr_stb) begin
                if (wq.size() == 0) begin
                    check("wr_unexp", 32'(wq.size()), 32'd1);
                end else begin
                    check("wr", {wr_addr, wr_data}, wq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_out(input logic b);
        sda_m = b;
        wt(Q);
        scl_m = 1'b1;
        wt(2 * Q);
        scl_m = 1'b0;
        wt(Q);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wt(Q);
        scl_m = 1'b1;
        wt(Q);
        sda_m = 1'b0;
        wt(Q);
        scl_m = 1'b0;
        wt(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wt(Q);
        scl_m = 1'b1;
        wt(Q);
        sda_m = 1'b1;
        wt(2 * Q);
    endtask

    task automatic send(input logic [7:0] b, input logic line_exp,
                        input string tag);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        sda_m = 1'b1;
        wt(Q);
        scl_m = 1'b1;
        wt(Q);
        check(tag, bus.sda_in, line_exp);
        wt(Q);
        scl_m = 1'b0;
        wt(Q);
    endtask

    task automatic recv(input logic mack);
        logic [7:0] d;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1;
            wt(Q);
            scl_m = 1'b1;
            wt(Q);
            d[i] = bus.sda_in;
            wt(Q);
            scl_m = 1'b0;
            wt(Q);
        end
        bit_out(!mack);
        check("rd", d, rq.pop_front());
    endtask

    task automatic wr_reg(input logic [3:0] p, input logic [7:0] d);
        start_c();
        send(8'h72, 1'b0, "ack_a");
        send({4'h0, p}, 1'b0, "ack_p");
        wq.push_back({p, d});
        model[p] = d;
        send(d, 1'b0, "ack_d");
        stop_c();
    endtask

    task automatic dbg_chk(input logic [3:0] p, input string tag);
        dbg_addr = p;
        #1;
        check(tag, dbg_data, model[p]);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        wt(3);
        check("rst_oe", bus.sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_adr", addressed, 1'b0);
        check("rst_stb", wr_stb, 1'b0);
        dbg_chk(4'd0, "rst_bank");
        rst = 1'b0;
        wt(4);

        // pointer + burst write
        start_c();
        check("busy_on", busy, 1'b1);
        send(8'h72, 1'b0, "ack_a");
        check("adr_on", addressed, 1'b1);
        send(8'h05, 1'b0, "ack_p");
        wq.push_back({4'd5, 8'hA1});
        model[5] = 8'hA1;
        send(8'hA1, 1'b0, "ack_d");
        wq.push_back({4'd6, 8'hB2});
        model[6] = 8'hB2;
        send(8'hB2, 1'b0, "ack_d");
        stop_c();
        check("busy_off", busy, 1'b0);
        check("adr_off", addressed, 1'b0);
        dbg_chk(4'd5, "bank5");
        dbg_chk(4'd6, "bank6");

        // burst read after repeated start
        start_c();
        send(8'h72, 1'b0, "ack_a");
        send(8'h05, 1'b0, "ack_p");
        start_c();
        send(8'h73, 1'b0, "ack_ar");
        rq.push_back(model[5]);
        recv(1'b1);
        rq.push_back(model[6]);
        recv(1'b0);
        check("rd_rel", bus.sda_oe, 1'b0);
        stop_c();

        // address mismatch
        oe_seen  = 1'b0;
        adr_seen = 1'b0;
        start_c();
        send(8'h74, 1'b1, "nack_a");
        send(8'h05, 1'b1, "nack_p");
        send(8'hFF, 1'b1, "nack_d");
        stop_c();
        check("miss_oe", oe_seen, 1'b0);
        check("miss_adr", adr_seen, 1'b0);
        dbg_chk(4'd5, "miss_bank5");

        // wrap, then a pointer-less read shows ptr ended at 1
        wr_reg(4'd1, 8'h77);
        start_c();
        send(8'h72, 1'b0, "ack_a");
        send(8'h0F, 1'b0, "ack_p");
        wq.push_back({4'd15, 8'h11});
        model[15] = 8'h11;
        send(8'h11, 1'b0, "ack_d");
        wq.push_back({4'd0, 8'h22});
        model[0] = 8'h22;
        send(8'h22, 1'b0, "ack_d");
        stop_c();
        dbg_chk(4'd15, "wrap15");
        dbg_chk(4'd0, "wrap0");
        start_c();
        send(8'h73, 1'b0, "ack_ar");
        rq.push_back(model[1]);
        recv(1'b0);
        stop_c();

        // abort mid-byte
        start_c();
        send(8'h72, 1'b0, "ack_a");
        send(8'h03, 1'b0, "ack_p");
        bit_out(1'b1);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b0);
        stop_c();
        check("abort_busy", busy, 1'b0);
        dbg_chk(4'd3, "abort_bank3");

        // reset while the target drives the address ACK
        start_c();
        for (int i = 7; i >= 0; i--) bit_out(8'h72 >> i);
        check("ack_drv", bus.sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_oe_now", bus.sda_oe, 1'b0);
        check("rst_busy_now", busy, 1'b0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        wt(2);
        rst = 1'b0;
        wt(2);
        dbg_chk(4'd5, "rst_bank5");
        dbg_chk(4'd15, "rst_bank15");
        stop_c();
        wr_reg(4'd2, 8'h5A);

        wt(4);
        for (int i = 0; i < 16; i++) dbg_chk(4'(i), "final_bank");
        check("wq_left", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
